hir_mac_pipe: RTL

- Parametrised pipelined multiply / multiply-accumulate unit for HIR-generated datapaths.
- Generalises the fixed 32-bit, fixed-latency multiplier helpers. Operand width, pipeline latency, signedness, accumulator width and saturation are configurable.
- Adds a per-issue op mode, an output-valid strobe, a term counter and a sticky overflow flag.
- Issued by the HIR schedule via tstart. Fully pipelined: one issue per cycle, no back-pressure.

---
 rtl/hir_mac_pkg.sv | 27 ++
 rtl/hir_pipe_valid.sv | 34 +++
 rtl/hir_mac_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hir_mac_pkg.sv
// Shared types and helpers for the HIR pipelined multiply / multiply-accumulate unit.
// Saturation limits are returned LIM_W wide; callers slice them down to their width.
package hir_mac_pkg;

  typedef enum logic [1:0] {
    OP_MUL     = 2'b00,
    OP_MAC     = 2'b01,
    OP_MAC_CLR = 2'b10,
    OP_RSVD    = 2'b11
  } hir_mac_op_e;

  localparam int LIM_W = 128;

  function automatic logic [LIM_W-1:0] sat_smax(input int w);
    sat_smax = (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  function automatic logic [LIM_W-1:0] sat_smin(input int w);
    sat_smin = LIM_W'(1) << (w - 1);
  endfunction

  function automatic logic [LIM_W-1:0] sat_umax(input int w);
    if (w >= LIM_W) sat_umax = '1;
    else            sat_umax = (LIM_W'(1) << w) - LIM_W'(1);
  endfunction

endpackage

// File: rtl/hir_pipe_valid.sv
// DEPTH-deep valid shift register with an op tag riding alongside, for HIR pipelined helpers.
// The op tag travels up to the stage before the last; the last stage is only the result strobe.
module hir_pipe_valid #(
  parameter int DEPTH = 3,
  parameter int OP_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  input  logic [OP_W-1:0] in_op,
  output logic            vld_pre,
  output logic [OP_W-1:0] op_pre,
  output logic            vld_last
);

  logic [DEPTH-1:0] vld_q;
  logic [OP_W-1:0]  op_q [DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH - 1; i++) op_q[i] <= '0;
    end else begin
      vld_q   <= {vld_q[DEPTH-2:0], in_vld};
      op_q[0] <= in_op;
      for (int i = 1; i < DEPTH - 1; i++) op_q[i] <= op_q[i-1];
    end
  end

  assign vld_pre  = vld_q[DEPTH-2];
  assign op_pre   = op_q[DEPTH-2];
  assign vld_last = vld_q[DEPTH-1];

endmodule

// File: rtl/hir_mac_pipe.sv
// Parametrised pipelined multiply / multiply-accumulate unit driven by the HIR schedule.
// Accumulator, term count and sticky overflow live only in the final (combine) stage.
module hir_mac_pipe
  import hir_mac_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ACC_W   = 48,
  parameter int LATENCY = 3,
  parameter int SIGNED  = 1,
  parameter int SAT     = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tstart,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [ACC_W-1:0] out,
  output logic             tdone,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // Handshake: tstart issues one op per cycle with no back-pressure; a, b, op are
  // sampled on that edge and tdone pulses for one cycle LATENCY edges later with out valid.

  if (LATENCY < 2) begin : g_bad_latency
    $error("hir_mac_pipe: LATENCY must be >= 2");
  end
  if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
    $error("hir_mac_pipe: ACC_W must be >= WIDTH+1");
  end

  localparam logic SGN    = (SIGNED != 0);
  localparam logic SAT_EN = (SAT != 0);
  localparam int   MSB    = ACC_W - 1;

  localparam logic [LIM_W-1:0] SMAX_F = sat_smax(ACC_W);
  localparam logic [LIM_W-1:0] SMIN_F = sat_smin(ACC_W);
  localparam logic [LIM_W-1:0] UMAX_F = sat_umax(ACC_W);
  localparam logic [ACC_W-1:0] SMAX   = SMAX_F[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMIN   = SMIN_F[ACC_W-1:0];
  localparam logic [ACC_W-1:0] UMAX   = UMAX_F[ACC_W-1:0];

  // Stage 1: operand capture
  logic [WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (tstart) begin
      a_q <= a;
      b_q <= b;
    end
  end

  logic       c_vld;
  logic [1:0] c_op;

  hir_pipe_valid #(
    .DEPTH (LATENCY),
    .OP_W  (2)
  ) u_pipe_valid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (tstart),
    .in_op    (op),
    .vld_pre  (c_vld),
    .op_pre   (c_op),
    .vld_last (tdone)
  );

  // Extending to ACC_W first and keeping the low ACC_W bits of the product equals the
  // full 2*WIDTH product truncated (or extended) to ACC_W, for either signedness.
  logic [ACC_W-1:0] a_ext, b_ext, prod;

  assign a_ext = {{(ACC_W-WIDTH){SGN & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{(ACC_W-WIDTH){SGN & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  logic [ACC_W-1:0] comb_p;

  if (LATENCY == 2) begin : g_direct
    assign comb_p = prod;
  end else begin : g_prod_pipe
    logic [ACC_W-1:0] p_q [LATENCY-2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY - 2; i++) p_q[i] <= '0;
      end else begin
        p_q[0] <= prod;
        for (int i = 1; i < LATENCY - 2; i++) p_q[i] <= p_q[i-1];
      end
    end

    assign comb_p = p_q[LATENCY-3];
  end

  // Combine stage
  logic [ACC_W-1:0] acc_q, acc_n, out_q, out_n, mac_res;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ovf_q, ovf_n, ovf_det;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, comb_p};
    ovf_det = 1'b0;
    if (SGN) ovf_det = (acc_q[MSB] == comb_p[MSB]) && (sum[MSB] != acc_q[MSB]);
    else     ovf_det = sum[ACC_W];
    mac_res = sum[ACC_W-1:0];
    if (ovf_det && SAT_EN) begin
      if (SGN) mac_res = acc_q[MSB] ? SMIN : SMAX;
      else     mac_res = UMAX;
    end
  end

  always_comb begin
    acc_n = acc_q;
    out_n = out_q;
    cnt_n = cnt_q;
    ovf_n = ovf_q;
    if (c_vld) begin
      case (hir_mac_op_e'(c_op))
        OP_MAC: begin
          acc_n = mac_res;
          out_n = mac_res;
          if (ovf_det) ovf_n = 1'b1;
          if (cnt_q != '1) cnt_n = cnt_q + CNT_W'(1);
        end
        OP_MAC_CLR: begin
          acc_n = comb_p;
          out_n = comb_p;
          cnt_n = CNT_W'(1);
          ovf_n = 1'b0;
        end
        default: out_n = comb_p;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_n;
      out_q <= out_n;
      cnt_q <= cnt_n;
      ovf_q <= ovf_n;
    end
  end

  assign out   = out_q;
  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule
